sdram_bank_ctrl: RTL and testbench
==================================

Name: sdram_bank_ctrl

Overview:
- Downstream of the SDRAM address mapper; consumes its registered bank/row/column triple plus a read/write flag.
- Tracks the open row of each bank and issues the minimal command sequence for the access: page hit gives RD/WR; bank idle gives ACT then RD/WR; page miss gives PRE, ACT, then RD/WR.
- Enforces tRP and tRCD.
- Services precharge-all requests from the refresh block.

Parameters:
- MAX_CSIZE, 11, column address width.
- MAX_RSIZE, 13, row/SDRAM address bus width (must be ≥12).
- BA_SIZE, 2, bank address width; number of banks = 2**BA_SIZE.
- TCNT_SIZE, 4, width of the timing inputs.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  asynchronous active-low reset.
- enable_i  in  1  init sequence complete; while low, no requests are accepted.
- trp_i  in  TCNT_SIZE  PRE-to-ACT delay in cycles; 0 is treated as 1.
- trcd_i  in  TCNT_SIZE  ACT-to-RD/WR delay in cycles; 0 is treated as 1.
- req_valid_i  in  1  access request.
- req_ready_o  out  1  request accepted when valid&ready.
- req_we_i  in  1  1=write, 0=read.
- bank_i  in  BA_SIZE  bank from the address mapper.
- row_i  in  MAX_RSIZE  row from the address mapper.
- column_i  in  MAX_CSIZE  column from the address mapper.
- refresh_req_i  in  1  level request: close all banks.
- refresh_ack_o  out  1  one-cycle pulse: all banks closed, tRP satisfied.
- cmd_o  out  3  command strobe: 0 NOP, 1 ACT, 2 RD, 3 WR, 4 PRE, 5 PREA.
- ba_o  out  BA_SIZE  bank for the command.
- addr_o  out  MAX_RSIZE  SDRAM A bus for the command.

Behaviour:
- Reset: state IDLE; all bank-open flags cleared; cmd_o=NOP, ba_o=0, addr_o=0, refresh_ack_o=0. Outputs go to these values immediately on rst_ni low, including mid-sequence; any in-flight request is dropped.
- Outputs cmd_o, ba_o, addr_o and refresh_ack_o are registered. cmd_o is NOP in every cycle not listed below.
- req_ready_o = enable_i & (state==IDLE) & !refresh_req_i. This is combinational from state and inputs, and is the only case where ready is high.
- On accept, the request (we, bank, row, column) is captured in an internal register. The inputs may change afterwards.
- Refresh has priority over a simultaneous req_valid_i in IDLE.
- Open-row table: per bank, an open flag plus the open row.
  - ACT sets the flag and stores the row.
  - PRE clears the flag for that bank.
  - PREA clears all flags.
- Decision, on the cycle after accept, using the captured bank:
  - Open and row matches: RD/WR on that cycle.
  - Closed: ACT on that cycle.
  - Open with a different row: PRE on that cycle.
- Timing:
  - PRE at cycle P gives ACT at P+max(trp_i,1).
  - ACT at cycle A gives RD/WR at A+max(trcd_i,1).
  - A downcounter is loaded at the issue cycle; NOPs are output while waiting.
- States: IDLE, DECIDE, WAIT_RP, ACT, WAIT_RCD, RW, PREA, WAIT_RPA. The RD/WR cycle returns to IDLE, so req_ready_o is high the cycle after RD/WR.
- Address formatting:
  - ACT: addr_o = row.
  - PRE: addr_o[10] = 0, other bits 0, ba_o = bank.
  - PREA: addr_o[10] = 1, ba_o = 0.
  - RD/WR: addr_o[9:0] = column[9:0], addr_o[10] = 0 (no auto-precharge), addr_o[11] = column[10] when MAX_CSIZE=11; unused bits are 0. ba_o = captured bank.
- Refresh in IDLE with refresh_req_i high:
  - If any bank is open: PREA in the next cycle, wait max(trp_i,1) cycles, then refresh_ack_o pulses one cycle and the state returns to IDLE.
  - If no bank is open: refresh_ack_o pulses in the next cycle with no PREA.
  - refresh_req_i rising mid-access is honoured only after the RD/WR returns to IDLE.
  - refresh_req_i still high the cycle after the ack starts a new refresh sequence. The refresh block must drop it on ack.
- trp_i/trcd_i are sampled when the corresponding counter loads; changes mid-wait have no effect.
- enable_i low never aborts a sequence in progress; it only blocks new accepts.

Test Plan:
- Reset, enable_i=1, trcd_i=2; read bank 1 row 0x055 col 0x012 accepted at cycle 0 → ACT ba=1 addr=0x055 at cycle 1; RD ba=1 addr=0x012 at cycle 3; ready high at cycle 4.
- Then write bank 1 row 0x055 col 0x7FF (11 cols) → WR one cycle after accept with addr[9:0]=0x3FF, addr[10]=0, addr[11]=1; no ACT/PRE.
- Page miss: bank 1 row 0x0AA, trp_i=3, trcd_i=2 → PRE ba=1 at cycle 1, ACT addr=0x0AA at cycle 4, WR/RD at cycle 6.
- trp_i=0, trcd_i=0 → treated as 1: ACT the cycle after PRE, RD the cycle after ACT.
- refresh_req_i and req_valid_i asserted together with bank 2 open → ready low, PREA with addr[10]=1, ack after trp_i, next access to bank 2 issues ACT; with all banks closed, ack the cycle after request and no PREA.
- Assert rst_ni low during WAIT_RCD → cmd_o NOP immediately, all banks closed; the next access to the same bank issues ACT, not RD.

Source files
------------

// File: rtl/sdram_bank_ctrl_if.sv
// sdram_bank_ctrl_if: request/command bundle for the SDRAM bank controller.
//   Request side : enable_i, req_valid_i/req_ready_o, req_we_i, bank_i, row_i, column_i
//   Timing       : trp_i, trcd_i (cycles, 0 behaves as 1)
//   Refresh      : refresh_req_i (level), refresh_ack_o (one-cycle pulse)
//   SDRAM command: cmd_o (0 NOP,1 ACT,2 RD,3 WR,4 PRE,5 PREA), ba_o, addr_o
// master = the mapper/refresh side, slave = the bank controller.
interface sdram_bank_ctrl_if #(
  parameter int MAX_CSIZE = 11,
  parameter int MAX_RSIZE = 13,
  parameter int BA_SIZE   = 2,
  parameter int TCNT_SIZE = 4
);
  logic                 enable_i;
  logic [TCNT_SIZE-1:0] trp_i;
  logic [TCNT_SIZE-1:0] trcd_i;
  logic                 req_valid_i;
  logic                 req_ready_o;
  logic                 req_we_i;
  logic [BA_SIZE-1:0]   bank_i;
  logic [MAX_RSIZE-1:0] row_i;
  logic [MAX_CSIZE-1:0] column_i;
  logic                 refresh_req_i;
  logic                 refresh_ack_o;
  logic [2:0]           cmd_o;
  logic [BA_SIZE-1:0]   ba_o;
  logic [MAX_RSIZE-1:0] addr_o;

  modport master (
    output enable_i, trp_i, trcd_i, req_valid_i, req_we_i, bank_i, row_i, column_i,
           refresh_req_i,
    input  req_ready_o, refresh_ack_o, cmd_o, ba_o, addr_o
  );

  modport slave (
    input  enable_i, trp_i, trcd_i, req_valid_i, req_we_i, bank_i, row_i, column_i,
           refresh_req_i,
    output req_ready_o, refresh_ack_o, cmd_o, ba_o, addr_o
  );
endinterface

// File: rtl/sdram_bank_ctrl.sv
// sdram_bank_ctrl: per-bank open-row tracking and SDRAM command sequencing.
// Issues RD/WR on a page hit, ACT+RD/WR on an idle bank and PRE+ACT+RD/WR on a
// page miss, honouring tRP/tRCD, and closes all banks on refresh request.
// Ports:
//   clk_i  - clock
//   rst_ni - asynchronous active-low reset
//   bus    - sdram_bank_ctrl_if.slave (request handshake, timing, refresh, command bus)
module sdram_bank_ctrl #(
  parameter int MAX_CSIZE = 11,
  parameter int MAX_RSIZE = 13,
  parameter int BA_SIZE   = 2,
  parameter int TCNT_SIZE = 4
) (
  input logic               clk_i,
  input logic               rst_ni,
  sdram_bank_ctrl_if.slave  bus
);
  localparam int NBANK = 2 ** BA_SIZE;

  localparam logic [2:0] CMD_NOP  = 3'd0;
  localparam logic [2:0] CMD_ACT  = 3'd1;
  localparam logic [2:0] CMD_RD   = 3'd2;
  localparam logic [2:0] CMD_WR   = 3'd3;
  localparam logic [2:0] CMD_PRE  = 3'd4;
  localparam logic [2:0] CMD_PREA = 3'd5;

  localparam logic [MAX_RSIZE-1:0] PREA_ADDR = {{(MAX_RSIZE-11){1'b0}}, 1'b1, 10'd0};

  typedef enum logic [2:0] {IDLE, DECIDE, WAIT_RP, ACT, WAIT_RCD, RW, PREA, WAIT_RPA} state_t;

  state_t               state;
  logic [TCNT_SIZE-1:0] cnt;
  logic                 cur_we;
  logic [BA_SIZE-1:0]   cur_bank;
  logic [MAX_RSIZE-1:0] cur_row;
  logic [MAX_CSIZE-1:0] cur_col;
  logic [NBANK-1:0]     bank_open;
  logic [MAX_RSIZE-1:0] open_row [NBANK];

  logic [2:0]           cmd;
  logic [BA_SIZE-1:0]   ba;
  logic [MAX_RSIZE-1:0] addr;
  logic                 ack;

  logic ready, accept, hit, rcd_phase, rp_phase;

  // Number of NOP cycles between two commands separated by t (0 behaves as 1).
  function automatic logic [TCNT_SIZE-1:0] wait_len(input logic [TCNT_SIZE-1:0] t);
    return (t == '0) ? '0 : t - 1'b1;
  endfunction

  // Column on the A bus: A[9:0] = col[9:0], A10 = 0 (no auto-precharge), A11 = col[10].
  function automatic logic [MAX_RSIZE-1:0] col_addr(input logic [MAX_CSIZE-1:0] col);
    logic [MAX_RSIZE-1:0] a;
    a      = '0;
    a[9:0] = col[9:0];
    if (MAX_CSIZE > 10) a[11] = col[MAX_CSIZE-1];
    return a;
  endfunction

  always_comb begin
    ready     = bus.enable_i && (state == IDLE) && !bus.refresh_req_i;
    accept    = ready && bus.req_valid_i;
    hit       = bank_open[bus.bank_i] && (open_row[bus.bank_i] == bus.row_i);
    // DECIDE is the cycle the first command is on the bus; the register tells which path follows.
    rcd_phase = (state == ACT) || (state == WAIT_RCD) || (state == DECIDE && cmd == CMD_ACT);
    rp_phase  = (state == WAIT_RP) || (state == DECIDE && cmd == CMD_PRE);
  end

  assign bus.req_ready_o   = ready;
  assign bus.cmd_o         = cmd;
  assign bus.ba_o          = ba;
  assign bus.addr_o        = addr;
  assign bus.refresh_ack_o = ack;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state     <= IDLE;
      cnt       <= '0;
      cur_we    <= 1'b0;
      cur_bank  <= '0;
      cur_row   <= '0;
      cur_col   <= '0;
      bank_open <= '0;
      for (int unsigned i = 0; i < NBANK; i++) open_row[i] <= '0;
      cmd       <= CMD_NOP;
      ba        <= '0;
      addr      <= '0;
      ack       <= 1'b0;
    end else begin
      cmd  <= CMD_NOP;
      ba   <= '0;
      addr <= '0;
      ack  <= 1'b0;
      if (state == IDLE) begin
        if (bus.refresh_req_i) begin
          if (|bank_open) begin
            cmd       <= CMD_PREA;
            addr      <= PREA_ADDR;
            bank_open <= '0;
            cnt       <= wait_len(bus.trp_i);
            state     <= PREA;
          end else begin
            ack <= 1'b1;
          end
        end else if (accept) begin
          // The first command is chosen from the live inputs on the accept edge so it
          // appears in the cycle right after accept; the same values are captured here.
          cur_we   <= bus.req_we_i;
          cur_bank <= bus.bank_i;
          cur_row  <= bus.row_i;
          cur_col  <= bus.column_i;
          ba       <= bus.bank_i;
          state    <= DECIDE;
          if (hit) begin
            cmd  <= bus.req_we_i ? CMD_WR : CMD_RD;
            addr <= col_addr(bus.column_i);
          end else if (!bank_open[bus.bank_i]) begin
            cmd                    <= CMD_ACT;
            addr                   <= bus.row_i;
            bank_open[bus.bank_i]  <= 1'b1;
            open_row[bus.bank_i]   <= bus.row_i;
            cnt                    <= wait_len(bus.trcd_i);
          end else begin
            cmd                   <= CMD_PRE;
            bank_open[bus.bank_i] <= 1'b0;
            cnt                   <= wait_len(bus.trp_i);
          end
        end
      end else if (rcd_phase) begin
        if (cnt == '0) begin
          cmd   <= cur_we ? CMD_WR : CMD_RD;
          ba    <= cur_bank;
          addr  <= col_addr(cur_col);
          state <= RW;
        end else begin
          cnt   <= cnt - 1'b1;
          state <= WAIT_RCD;
        end
      end else if (rp_phase) begin
        if (cnt == '0) begin
          cmd                <= CMD_ACT;
          ba                 <= cur_bank;
          addr               <= cur_row;
          bank_open[cur_bank] <= 1'b1;
          open_row[cur_bank]  <= cur_row;
          cnt                <= wait_len(bus.trcd_i);
          state              <= ACT;
        end else begin
          cnt   <= cnt - 1'b1;
          state <= WAIT_RP;
        end
      end else if (state == PREA || state == WAIT_RPA) begin
        if (cnt == '0) begin
          ack   <= 1'b1;
          state <= IDLE;
        end else begin
          cnt   <= cnt - 1'b1;
          state <= WAIT_RPA;
        end
      end else begin
        // RW, or DECIDE after a page hit: the access is complete.
        state <= IDLE;
      end
    end
  end
endmodule

// File: tb/tb_sdram_bank_ctrl.sv
// tb_sdram_bank_ctrl: directed test-plan sequences plus randomized traffic, all
// checked cycle by cycle against a transaction-level model of the bank controller.
module tb_sdram_bank_ctrl;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  sdram_bank_ctrl_if #(.MAX_CSIZE(11), .MAX_RSIZE(13), .BA_SIZE(2), .TCNT_SIZE(4)) bus ();

  sdram_bank_ctrl #(.MAX_CSIZE(11), .MAX_RSIZE(13), .BA_SIZE(2), .TCNT_SIZE(4)) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus)
  );

  typedef struct {
    int cyc;
    int cmd;
    int ba;
    int addr;
  } ev_t;

  ev_t q[$];
  int  errors = 0;
  int  checks = 0;
  int  k = 0;
  int  idle_from = 0;
  int  ack_cycle = -1;
  bit  m_open[4];
  int  m_row[4];
  int  obs_cmd, obs_ba, obs_addr, obs_ack, obs_ready;
  bit  ref_pending = 1'b0;
  int  cur_tp = 0, cur_tc = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", name, k, act, exp);
    end
  endtask

  function automatic int max1(input int t);
    return (t == 0) ? 1 : t;
  endfunction

  function automatic int rw_addr(input int col);
    return (col % 1024) + (col / 1024) * 2048;
  endfunction

  task automatic push(input int cyc, input int cmd, input int ba, input int addr);
    ev_t e;
    e.cyc = cyc; e.cmd = cmd; e.ba = ba; e.addr = addr;
    q.push_back(e);
  endtask

  // One clock cycle: check the registered outputs for cycle k, drive inputs,
  // check ready, then advance the model.
  task automatic step(input bit v, input bit we, input int b, input int r, input int c,
                      input bit rf, input bit en, input int tp, input int tc);
    ev_t e;
    int  t;
    bit  exp_ready;
    @(negedge clk);
    if (q.size() != 0 && q[0].cyc == k) e = q.pop_front();
    else begin
      e.cyc = k; e.cmd = 0; e.ba = 0; e.addr = 0;
    end
    obs_cmd  = int'(bus.cmd_o);
    obs_ba   = int'(bus.ba_o);
    obs_addr = int'(bus.addr_o);
    obs_ack  = int'(bus.refresh_ack_o);
    chk("cmd", obs_cmd, e.cmd);
    if (e.cmd != 0) begin
      chk("ba", obs_ba, e.ba);
      chk("addr", obs_addr, e.addr);
    end
    chk("ack", obs_ack, (k == ack_cycle) ? 1 : 0);

    bus.req_valid_i   = v;
    bus.req_we_i      = we;
    bus.bank_i        = b[1:0];
    bus.row_i         = r[12:0];
    bus.column_i      = c[10:0];
    bus.refresh_req_i = rf;
    bus.enable_i      = en;
    bus.trp_i         = tp[3:0];
    bus.trcd_i        = tc[3:0];
    #1;
    obs_ready = int'(bus.req_ready_o);
    exp_ready = en && (k >= idle_from) && !rf;
    chk("ready", obs_ready, exp_ready ? 1 : 0);

    if (rf && k >= idle_from) begin
      if (m_open[0] || m_open[1] || m_open[2] || m_open[3]) begin
        push(k + 1, 5, 0, 1024);
        ack_cycle = k + 1 + max1(tp);
        idle_from = ack_cycle;
        for (int i = 0; i < 4; i++) m_open[i] = 1'b0;
      end else begin
        ack_cycle = k + 1;
        idle_from = k + 1;
      end
    end else if (v && exp_ready) begin
      t = k + 1;
      if (m_open[b] && m_row[b] == r) begin
        push(t, we ? 3 : 2, b, rw_addr(c));
      end else begin
        if (m_open[b]) begin
          push(t, 4, b, 0);
          t += max1(tp);
        end
        push(t, 1, b, r);
        t += max1(tc);
        push(t, we ? 3 : 2, b, rw_addr(c));
        m_open[b] = 1'b1;
        m_row[b]  = r;
      end
      idle_from = t + 1;
    end
    k++;
  endtask

  task automatic idle_c(input bit rf, input int tp, input int tc);
    step(1'b0, 1'b0, 0, 0, 0, rf, 1'b1, tp, tc);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    chk("rst_cmd", int'(bus.cmd_o), 0);
    chk("rst_ba", int'(bus.ba_o), 0);
    chk("rst_addr", int'(bus.addr_o), 0);
    chk("rst_ack", int'(bus.refresh_ack_o), 0);
    bus.req_valid_i   = 1'b0;
    bus.refresh_req_i = 1'b0;
    q.delete();
    for (int i = 0; i < 4; i++) m_open[i] = 1'b0;
    ack_cycle   = -1;
    ref_pending = 1'b0;
    idle_from   = 0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    int r, b, c;
    bit v, we, en;
    rst_n             = 1'b0;
    bus.enable_i      = 1'b0;
    bus.trp_i         = '0;
    bus.trcd_i        = '0;
    bus.req_valid_i   = 1'b0;
    bus.req_we_i      = 1'b0;
    bus.bank_i        = '0;
    bus.row_i         = '0;
    bus.column_i      = '0;
    bus.refresh_req_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      m_open[i] = 1'b0;
      m_row[i]  = 0;
    end
    repeat (2) @(negedge clk);
    chk("reset_cmd", int'(bus.cmd_o), 0);
    chk("reset_ba", int'(bus.ba_o), 0);
    chk("reset_addr", int'(bus.addr_o), 0);
    chk("reset_ack", int'(bus.refresh_ack_o), 0);
    rst_n = 1'b1;

    // enable low blocks accepts
    step(1'b1, 1'b0, 0, 0, 0, 1'b0, 1'b0, 0, 0);
    chk("en_low_ready", obs_ready, 0);
    // refresh with every bank closed: ack next cycle, no PREA
    step(1'b0, 1'b0, 0, 0, 0, 1'b1, 1'b1, 0, 0);
    idle_c(1'b0, 0, 0);
    chk("ack_closed", obs_ack, 1);
    chk("ack_closed_cmd", obs_cmd, 0);

    // idle bank: ACT then RD after tRCD=2
    step(1'b1, 1'b0, 1, 'h055, 'h012, 1'b0, 1'b1, 0, 2);
    chk("tp1_ready", obs_ready, 1);
    idle_c(1'b0, 0, 2);
    chk("tp1_act_cmd", obs_cmd, 1);
    chk("tp1_act_ba", obs_ba, 1);
    chk("tp1_act_addr", obs_addr, 'h055);
    idle_c(1'b0, 0, 2);
    chk("tp1_nop", obs_cmd, 0);
    idle_c(1'b0, 0, 2);
    chk("tp1_rd_cmd", obs_cmd, 2);
    chk("tp1_rd_addr", obs_addr, 'h012);
    // page hit write, column 0x7FF
    step(1'b1, 1'b1, 1, 'h055, 'h7FF, 1'b0, 1'b1, 0, 2);
    chk("tp2_ready", obs_ready, 1);
    idle_c(1'b0, 0, 2);
    chk("tp2_wr_cmd", obs_cmd, 3);
    chk("tp2_wr_addr", obs_addr, 'hBFF);

    // page miss, tRP=3 tRCD=2
    step(1'b1, 1'b1, 1, 'h0AA, 'h010, 1'b0, 1'b1, 3, 2);
    idle_c(1'b0, 3, 2);
    chk("tp3_pre_cmd", obs_cmd, 4);
    chk("tp3_pre_ba", obs_ba, 1);
    idle_c(1'b0, 3, 2);
    idle_c(1'b0, 3, 2);
    idle_c(1'b0, 3, 2);
    chk("tp3_act_cmd", obs_cmd, 1);
    chk("tp3_act_addr", obs_addr, 'h0AA);
    idle_c(1'b0, 3, 2);
    idle_c(1'b0, 3, 2);
    chk("tp3_wr_cmd", obs_cmd, 3);

    // zero timing behaves as one
    step(1'b1, 1'b0, 1, 'h055, 'h001, 1'b0, 1'b1, 0, 0);
    idle_c(1'b0, 0, 0);
    chk("tp4_pre", obs_cmd, 4);
    idle_c(1'b0, 0, 0);
    chk("tp4_act", obs_cmd, 1);
    idle_c(1'b0, 0, 0);
    chk("tp4_rd", obs_cmd, 2);

    // refresh beats a simultaneous request while bank 2 is open
    step(1'b1, 1'b0, 2, 'h033, 'h005, 1'b0, 1'b1, 0, 0);
    idle_c(1'b0, 0, 0);
    idle_c(1'b0, 0, 0);
    step(1'b1, 1'b0, 2, 'h033, 'h005, 1'b1, 1'b1, 2, 0);
    chk("tp5_ready_low", obs_ready, 0);
    idle_c(1'b1, 2, 0);
    chk("tp5_prea_cmd", obs_cmd, 5);
    chk("tp5_prea_addr", obs_addr, 'h400);
    chk("tp5_prea_ba", obs_ba, 0);
    idle_c(1'b1, 2, 0);
    idle_c(1'b0, 2, 0);
    chk("tp5_ack", obs_ack, 1);
    step(1'b1, 1'b0, 2, 'h033, 'h005, 1'b0, 1'b1, 2, 0);
    idle_c(1'b0, 2, 0);
    chk("tp5_reopen_act", obs_cmd, 1);
    idle_c(1'b0, 2, 0);
    chk("tp5_rd", obs_cmd, 2);

    // reset during the tRCD wait closes every bank
    step(1'b1, 1'b0, 3, 'h123, 'h044, 1'b0, 1'b1, 0, 5);
    idle_c(1'b0, 0, 5);
    chk("tp6_act", obs_cmd, 1);
    idle_c(1'b0, 0, 5);
    do_reset();
    step(1'b0, 1'b0, 0, 0, 0, 1'b1, 1'b1, 0, 0);
    idle_c(1'b0, 0, 0);
    chk("tp6_ack_closed", obs_ack, 1);
    step(1'b1, 1'b0, 3, 'h123, 'h044, 1'b0, 1'b1, 0, 0);
    idle_c(1'b0, 0, 0);
    chk("tp6_act_again", obs_cmd, 1);
    idle_c(1'b0, 0, 0);
    chk("tp6_rd", obs_cmd, 2);

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      if (k >= idle_from) begin
        cur_tp = $urandom_range(0, 4);
        cur_tc = $urandom_range(0, 4);
      end
      if (k == ack_cycle) ref_pending = 1'b0;
      else if (!ref_pending && $urandom_range(0, 24) == 0) ref_pending = 1'b1;
      case ($urandom_range(0, 2))
        0:       r = 'h055;
        1:       r = 'h0AA;
        default: r = $urandom_range(0, 8191);
      endcase
      b  = $urandom_range(0, 3);
      c  = $urandom_range(0, 2047);
      v  = ($urandom_range(0, 2) != 0);
      we = $urandom_range(0, 1) != 0;
      en = ($urandom_range(0, 7) != 0);
      step(v, we, b, r, c, ref_pending, en, cur_tp, cur_tc);
      if (i == 1500) do_reset();
    end

    // let the last sequence finish
    for (int i = 0; i < 64 && (q.size() != 0 || k <= ack_cycle); i++) begin
      if (k == ack_cycle) ref_pending = 1'b0;
      step(1'b0, 1'b0, 0, 0, 0, ref_pending, 1'b1, cur_tp, cur_tc);
    end
    chk("drain", q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
